// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the reference-clock domain.
// Drives the PLL reset, qualifies its lock output and releases a system reset
// only after lock has been stable; retries on timeout and re-resets on loss.
//
// Ports:
//   refclk      in   reference clock, all logic on its rising edge
//   rst         in   asynchronous active-high reset
//   locked      in   PLL lock indicator, asynchronous to refclk
//   soft_req    in   single-cycle request to re-initialise the PLL
//   pll_rst     out  registered active-high reset to the PLL
//   sys_reset   out  registered lock-qualified system reset (active-high)
//   ready       out  high exactly while in RUN
//   retry_count out  number of lock timeouts, saturating at 255
//   lock_lost   out  sticky flag, set when lock drops in RUN

module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic       lock_lost
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT)
                         ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [1:0] PRST   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] STABLE = 2'd2;
    localparam logic [1:0] RUN    = 2'd3;

    localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retry_q, retry_d;
    logic          lost_q, lost_d;
    logic          pll_rst_q;
    logic          sys_reset_q;
    logic          ready_q;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    // soft_req outranks lock drop and timeout, so neither status
    // counter nor sticky flag moves on a requested restart.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            PRST: begin
                if (cnt_q == PRST_LAST) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (soft_req) begin
                    state_d = PRST;
                end else if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = PRST;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end
            end
            STABLE: begin
                if (soft_req) begin
                    state_d = PRST;
                end else if (!locked_s) begin
                    state_d = WAIT;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (soft_req) begin
                    state_d = PRST;
                end else if (!locked_s) begin
                    state_d = PRST;
                    lost_d  = 1'b1;
                end
            end
            default: begin
                state_d = PRST;
            end
        endcase
    end

    // Counter restarts on every state change and idles in RUN.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != RUN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change on the
    // same edge as the state, keeping sys_reset low only inside RUN.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= PRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= (state_d == PRST);
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign retry_count = retry_q;
    assign lock_lost   = lost_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises the system PLL on the reference-clock domain.
- Drives the PLL's reset input and watches its asynchronous `locked` output.
- Releases a clean, lock-qualified system reset only after lock has stayed stable.
- On lock timeout or lock loss, re-resets the PLL automatically and reports retry and loss status for the menu core.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the `locked` synchroniser (min 2).
- PLL_RST_CYCLES, 16, refclk cycles `pll_rst` is held high per PLL reset pulse (min 1).
- LOCK_TIMEOUT, 50000, refclk cycles to wait for lock before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before releasing `sys_reset`.

Ports:
- refclk  in  1  reference clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  PLL lock indicator; asynchronous to refclk.
- soft_req  in  1  single-cycle request to re-initialise the PLL (synchronous to refclk).
- pll_rst  out  1  reset to the PLL, active-high, registered.
- sys_reset  out  1  lock-qualified system reset, active-high, registered; consumers resynchronise into their own domains.
- ready  out  1  high exactly while in state RUN.
- retry_count  out  8  number of lock timeouts, saturating at 255.
- lock_lost  out  1  sticky flag, set when lock drops while in RUN; cleared only by `rst`.

Behaviour:
- Synchroniser: `locked_s` is `locked` after SYNC_STAGES flops. All decisions use `locked_s` only.
- Reset values (while `rst` is high):
  - state = PRST, counter = 0, synchroniser = 0
  - pll_rst = 1, sys_reset = 1, ready = 0, retry_count = 0, lock_lost = 0
- Counter: a single shared counter, width `$clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1`. It clears on every state change.
- State PRST:
  - pll_rst = 1, sys_reset = 1.
  - Count PLL_RST_CYCLES cycles, then go to WAIT.
  - `pll_rst` falls on the first WAIT cycle, so after `rst` release it is high for exactly PLL_RST_CYCLES cycles.
- State WAIT:
  - pll_rst = 0, sys_reset = 1.
  - If `locked_s` = 1, go to STABLE.
  - Else, if counter reaches LOCK_TIMEOUT−1, go to PRST and increment retry_count (saturating at 255).
  - If lock arrives on the timeout cycle, lock wins: go to STABLE, no increment.
- State STABLE:
  - sys_reset = 1.
  - If `locked_s` = 0, go to WAIT (counter cleared, timeout restarts).
  - When STABLE_CYCLES consecutive high cycles have elapsed, including the entry cycle, go to RUN.
- State RUN:
  - sys_reset = 0, ready = 1; both outputs are registered and change on entry to RUN.
  - If `locked_s` = 0, go to PRST and set lock_lost.
- soft_req:
  - In any state except PRST, go to PRST at the next edge.
  - soft_req has priority over a simultaneous lock drop or timeout: lock_lost is not set and retry_count is not incremented.
  - Ignored while in PRST; the counter is not restarted.
- Output glitch rule: `sys_reset` reasserts on the same edge that leaves RUN, so no cycle of `sys_reset` = 0 occurs outside RUN.
- Mid-operation `rst`:
  - All state clears immediately (asynchronous).
  - pll_rst = 1 and sys_reset = 1 asynchronously.
  - Deassertion of `rst` is assumed synchronous to refclk by the top level.
- `locked` glitches shorter than one refclk period may or may not be seen; any sampled low in STABLE or RUN is treated as a real drop.

Test Plan:
All scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8.
- Clean start: release `rst`, raise `locked` 10 cycles after `pll_rst` falls.
  - `pll_rst` is high for exactly 4 cycles after release.
  - `sys_reset` falls and `ready` rises exactly 2+8 cycles after `locked` rises (2 sync + 8 stable; allow ±1 for registered transition and check the exact value against RTL).
  - retry_count = 0.
- Timeout retry: hold `locked` = 0 for 250 cycles after release.
  - `pll_rst` re-pulses (4 cycles high) twice.
  - retry_count = 2.
  - `sys_reset` stays 1 throughout.
- Unstable lock: `locked` high for 5 cycles, low for 1, then high permanently.
  - No RUN after the first 5-cycle high.
  - RUN is reached 8 stable cycles after the final rise.
  - retry_count = 0.
- Lock loss in RUN: drop `locked` for 3 cycles.
  - `sys_reset` = 1 two cycles after the drop.
  - `pll_rst` pulses for 4 cycles.
  - lock_lost = 1 and stays 1 after relock.
- soft_req priority: in RUN, assert soft_req on the same cycle `locked_s` falls.
  - Next state is PRST.
  - lock_lost stays 0; retry_count is unchanged.
- Async reset mid-STABLE: assert `rst` for half a cycle.
  - `pll_rst` and `sys_reset` go 1 immediately.
  - All counters and flags read 0 after release.
